tcm_dump: RTL
=============

# tcm_dump

Memory readback engine for the SCR1 top: reads a block of 32-bit words from TCM over a simple request/response port and streams them out as a little-endian byte stream, byte-for-byte identical to the `.bin` image format loaded into TCM. Sits between the TCM data port and a byte sink (UART TX or debug FIFO). Used to dump program and data memory for comparison against the source image.

## Interface
- ADDR_W, 32, memory address width (byte address)
- CNT_W, 16, width of word-count input
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start pulse; sampled only in IDLE
- abort_i  in  1  abort; returns to IDLE next cycle from any state
- base_addr_i  in  ADDR_W  first byte address; bits [1:0] ignored (forced 0)
- word_cnt_i  in  CNT_W  number of words to dump
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse on normal completion
- mem_req_o  out  1  read request, held until accepted
- mem_addr_o  out  ADDR_W  word-aligned read address
- mem_ack_i  in  1  request accepted when mem_req_o & mem_ack_i
- mem_rvalid_i  in  1  read data valid, ≥1 cycle after accept
- mem_rdata_i  in  32  read data
- byte_o  out  8  output byte
- byte_valid_o  out  1  byte_o valid
- byte_ready_i  in  1  sink accepts when byte_valid_o & byte_ready_i

## Operation
- States: IDLE, REQ, WAIT, SEND, CSUM, DONE.
- IDLE: start_i=1 latches base_addr_i (bits [1:0]=0) and word_cnt_i. Count 0 -> DONE; else -> REQ.
- REQ: mem_req_o=1, mem_addr_o=current address. On accept -> WAIT; address += 4, mod 2^ADDR_W wrap; remaining count −1.
- WAIT: on mem_rvalid_i capture mem_rdata_i into word register -> SEND, byte index 0. mem_rvalid_i outside WAIT ignored.
- SEND: byte_o = word[8*idx+7:8*idx], little-endian, idx 0..3. Each handshake increments idx. After idx 3 handshake: remaining >0 -> REQ, else -> CSUM if enabled, else DONE.
- CSUM: see Configuration. DONE: done_o=1 for one cycle -> IDLE.
- abort_i has priority over all transitions: next state IDLE, mem_req_o and byte_valid_o drop the following cycle, no done_o. A read already accepted whose rvalid arrives later is discarded.
- start_i while busy_o=1 ignored.
- Only one outstanding memory read; no prefetch.

## Timing
- Reset values: busy_o=0, done_o=0, mem_req_o=0, mem_addr_o=0, byte_valid_o=0, byte_o=0; internal state IDLE, counters 0.
- All outputs registered.
- start_i at edge N -> mem_req_o=1 from cycle N+1.
- Zero-wait memory (ack same cycle as req, rvalid next cycle) and sink always ready: 6 cycles per word (REQ 1, WAIT 1, SEND 4).
- Capture at edge M -> byte_valid_o=1 with byte 0 from cycle M+1.
- byte_o and byte_valid_o stable while byte_ready_i=0.
- Last byte handshake at edge K -> done_o=1 in cycle K+1 (no checksum), busy_o=0 from cycle K+2.
- word_cnt_i=0: done_o in cycle N+1, no memory or byte traffic.
- Max dump 2^CNT_W−1 words; address wrap from 0xFFFF_FFFC to 0 is legal.

## Configuration
- TCM_DUMP_CHECKSUM_EN defined: 32-bit running sum (mod 2^32) of all captured words, cleared on start. After the last data byte, CSUM sends 4 extra bytes, sum little-endian, same handshake, then DONE.
- Not defined: CSUM state and sum register absent; SEND goes straight to DONE; stream is exactly 4×word_cnt bytes.

## Test plan
- Base 0x0000_0100, count 2, memory words 0x11223344, 0xAABBCCDD, sink always ready -> bytes 44 33 22 11 DD CC BB AA; addresses 0x100, 0x104; done_o 1 cycle; 12 cycles start-to-last-byte.
- Sink backpressure: byte_ready_i low 3 cycles on byte 2 of word 0x0A0B0C0D -> byte_o holds 0x0B steady; sequence unchanged.
- Memory ack delayed 4 cycles, rvalid 2 cycles after accept -> mem_req_o and mem_addr_o held until ack; data correct.
- Count 0 -> done_o at N+1, no mem_req_o, no byte_valid_o. Base 0xFFFF_FFFC, count 2 -> addresses 0xFFFF_FFFC then 0x0000_0000.
- abort_i while in WAIT; late rvalid with 0xDEADBEEF -> IDLE, no bytes, no done_o; next start dumps correctly.
- With TCM_DUMP_CHECKSUM_EN: words 0x0000_0001, 0xFFFF_FFFF -> data bytes followed by 00 00 00 00 (sum wraps to 0).

Source files
------------

// File: rtl/tcm_dump.sv
// TCM readback engine: reads word_cnt words from TCM and streams them as little-endian bytes.
// Optional trailing 32-bit word sum enabled by defining TCM_DUMP_CHECKSUM_EN.
module tcm_dump #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_cnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
`ifdef TCM_DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              mem_req_q, mem_req_d;
  logic [7:0]        byte_q, byte_d;
  logic              byte_valid_q, byte_valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
`ifdef TCM_DUMP_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  logic       mem_accept;
  logic       byte_hs;
  logic [1:0] nxt_idx;
  // Address bits [1:0] are forced to zero, so the incoming ones are never consumed.
  logic       unused_addr_bits;

  assign mem_accept       = mem_req_q & mem_ack_i;
  assign byte_hs          = byte_valid_q & byte_ready_i;
  assign nxt_idx          = idx_q + 2'd1;
  assign unused_addr_bits = ^base_addr_i[1:0];

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a value unassigned (no latches).
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    word_d       = word_q;
    idx_d        = idx_q;
    mem_req_d    = mem_req_q;
    byte_d       = byte_q;
    byte_valid_d = byte_valid_q;
    done_d       = 1'b0;
`ifdef TCM_DUMP_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d   = {base_addr_i[ADDR_W-1:2], 2'b00};
          remain_d = word_cnt_i;
          idx_d    = 2'd0;
`ifdef TCM_DUMP_CHECKSUM_EN
          sum_d    = 32'd0;
`endif
          if (word_cnt_i == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        if (mem_accept) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
          addr_d    = addr_q + ADDR_W'(4);
          remain_d  = remain_q - CNT_W'(1);
        end
      end

      S_WAIT: begin
        if (mem_rvalid_i) begin
          state_d      = S_SEND;
          word_d       = mem_rdata_i;
          idx_d        = 2'd0;
          byte_d       = mem_rdata_i[7:0];
          byte_valid_d = 1'b1;
`ifdef TCM_DUMP_CHECKSUM_EN
          sum_d        = sum_q + mem_rdata_i;
`endif
        end
      end

      S_SEND: begin
        if (byte_hs) begin
          if (idx_q != 2'd3) begin
            idx_d  = nxt_idx;
            byte_d = word_q[{nxt_idx, 3'b000} +: 8];
          end else begin
            idx_d = 2'd0;
            if (remain_q != '0) begin
              state_d      = S_REQ;
              mem_req_d    = 1'b1;
              byte_valid_d = 1'b0;
            end else begin
`ifdef TCM_DUMP_CHECKSUM_EN
              state_d = S_CSUM;
              byte_d  = sum_q[7:0];
`else
              state_d      = S_DONE;
              done_d       = 1'b1;
              byte_valid_d = 1'b0;
`endif
            end
          end
        end
      end

`ifdef TCM_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (byte_hs) begin
          if (idx_q != 2'd3) begin
            idx_d  = nxt_idx;
            byte_d = sum_q[{nxt_idx, 3'b000} +: 8];
          end else begin
            idx_d        = 2'd0;
            state_d      = S_DONE;
            done_d       = 1'b1;
            byte_valid_d = 1'b0;
          end
        end
      end
`endif

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything; a read already in flight is dropped since WAIT is left.
    if (abort_i) begin
      state_d      = S_IDLE;
      mem_req_d    = 1'b0;
      byte_valid_d = 1'b0;
      done_d       = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      word_q       <= '0;
      idx_q        <= 2'd0;
      mem_req_q    <= 1'b0;
      byte_q       <= 8'd0;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef TCM_DUMP_CHECKSUM_EN
      sum_q        <= 32'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      mem_req_q    <= mem_req_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
`ifdef TCM_DUMP_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = addr_q;
  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;

endmodule
